alu_operand_stage: RTL

Parametrised successor to the 2:1 ALU input select. Selects ALU operands A and B independently from `NSRC` candidate sources, such as the register file, immediate, PC or forwarded results. Registers both operands into a 2-entry skid buffer with a valid/ready handshake. Sits between decode/forwarding and the ALU, so the ALU sees registered operands and back-pressure never creates a combinational path from `out_ready` to `in_ready`.

---
 rtl/alu_operand_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Picks ALU operands A and B independently from NSRC candidate sources and
// holds the selected pair in a 2-entry skid buffer (main + skid) behind a
// valid/ready handshake. The main entry drives the outputs directly, and
// in_ready comes from a flop, so out_ready never reaches in_ready
// combinationally.
//
// Optional feature macro: ALU_OPSTAGE_SEL_CHECK_EN
//   defined   -> sel_err is a sticky flag set by an accepted out-of-range select
//   undefined -> sel_err is tied to 0 and the check logic is absent
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   src        NSRC*WIDTH flattened sources, source k at src[k*WIDTH +: WIDTH]
//   sel_a      source index for operand A
//   sel_b      source index for operand B
//   in_valid   src/sel_* valid this cycle
//   in_ready   stage can accept (registered)
//   flush      synchronous discard of all buffered entries
//   op_a       selected operand A
//   op_b       selected operand B
//   out_valid  op_a/op_b valid
//   out_ready  ALU consumes this cycle
//   sel_err    sticky out-of-range select flag
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 4,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [SELW-1:0]       sel_a,
    input  logic [SELW-1:0]       sel_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Indices with no matching source (only reachable for non-power-of-two
    // NSRC) fall through the loop and return zero.
    function automatic logic [WIDTH-1:0] sel_operand(
        input logic [NSRC*WIDTH-1:0] s,
        input logic [SELW-1:0]       idx
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (idx == SELW'(k)) v = s[k*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t            r_state;
    logic              r_in_ready;
    logic [WIDTH-1:0]  r_main_a_p1;
    logic [WIDTH-1:0]  r_main_b_p1;
    logic [WIDTH-1:0]  r_skid_a_p1;
    logic [WIDTH-1:0]  r_skid_b_p1;
    logic [15:0]       r_stall_cnt;

    logic [WIDTH-1:0]  w_op_a_p0;
    logic [WIDTH-1:0]  w_op_b_p0;
    logic              w_vld_p1;
    logic              w_acc;
    logic              w_pop;

    // ---- stage p0: combinational operand select on the input side ----
    assign w_op_a_p0 = sel_operand(src, sel_a);
    assign w_op_b_p0 = sel_operand(src, sel_b);

    assign w_vld_p1  = (r_state != ST_EMPTY);
    assign w_acc     = in_valid && r_in_ready;
    assign w_pop     = w_vld_p1 && out_ready;

    // ---- stage p1: main/skid storage, handshake state, stall counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_a_p1 <= '0;
            r_main_b_p1 <= '0;
            r_skid_a_p1 <= '0;
            r_skid_b_p1 <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_vld_p1 && !out_ready) r_stall_cnt <= sat_inc16(r_stall_cnt);

            if (flush) begin
                // Any accept in this cycle is dropped along with the buffer.
                r_state    <= ST_EMPTY;
                r_in_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            r_main_a_p1 <= w_op_a_p0;
                            r_main_b_p1 <= w_op_b_p0;
                            r_state     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && !w_pop) begin
                            r_skid_a_p1 <= w_op_a_p0;
                            r_skid_b_p1 <= w_op_b_p0;
                            r_state     <= ST_TWO;
                            r_in_ready  <= 1'b0;
                        end else if (w_acc && w_pop) begin
                            r_main_a_p1 <= w_op_a_p0;
                            r_main_b_p1 <= w_op_b_p0;
                        end else if (w_pop) begin
                            r_state     <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // in_ready is 0 here, so only a pop can happen.
                        if (w_pop) begin
                            r_main_a_p1 <= r_skid_a_p1;
                            r_main_b_p1 <= r_skid_b_p1;
                            r_state     <= ST_ONE;
                            r_in_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_EMPTY;
                        r_in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef ALU_OPSTAGE_SEL_CHECK_EN
    logic r_sel_err;

    // Only pairs that actually enter the buffer can raise the flag; a pair
    // discarded by flush never produces a zeroed operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_acc && !flush &&
                     ((int'(sel_a) >= NSRC) || (int'(sel_b) >= NSRC))) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign sel_err = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = w_vld_p1;
    assign op_a      = r_main_a_p1;
    assign op_b      = r_main_b_p1;
    assign stall_cnt = r_stall_cnt;

endmodule
